dual_port_ram: RTL and testbench

- Simple dual-port synchronous RAM; the storage element behind the FIFO.
- Port A is read-only: the FIFO drives the front (pop) address and reads data out.
- Port B is write-only: the FIFO drives the rear (push) address and writes data in.
- Single clock domain; maps onto block RAM.

---
 rtl/dual_port_ram_pkg.sv | 5 +
 rtl/dual_port_ram.sv | 54 +++++
 tb/tb_dual_port_ram.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/dual_port_ram_pkg.sv
// Default geometry of the FIFO storage RAM, shared with the FIFO that instantiates it.
package dual_port_ram_pkg;
    localparam int DPR_DATA_WIDTH = 8;
    localparam int DPR_ADDR_WIDTH = 13;
endpackage

// File: rtl/dual_port_ram.sv
// Simple dual-port RAM behind the FIFO: port A registered read (1 clock), port B write.
// Read-first on same-address collision; no backpressure, every enabled edge is accepted.
module dual_port_ram
    import dual_port_ram_pkg::*;
#(
    parameter int DATA_WIDTH = DPR_DATA_WIDTH,
    parameter int ADDR_WIDTH = DPR_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addra,
    output logic [DATA_WIDTH-1:0] douta,
    input  logic                  wea,
    input  logic                  ena,
    input  logic [ADDR_WIDTH-1:0] addrb,
    input  logic [DATA_WIDTH-1:0] dinb,
    input  logic                  web,
    input  logic                  enb
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Zero-initialised so unwritten words never read as X; reset leaves contents alone.
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

    logic [DATA_WIDTH-1:0] douta_d;
    logic [DATA_WIDTH-1:0] douta_q;

    // wea/enb exist only for pinout compatibility with the FIFO hookup.
    logic unused_pins;
    assign unused_pins = wea | enb;

    always_ff @(posedge clock) begin
        if (web && !reset) begin
            mem[addrb] <= dinb;
        end
    end

    always_comb begin
        douta_d = douta_q;
        if (ena) begin
            douta_d = mem[addra];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            douta_q <= '0;
        end else begin
            douta_q <= douta_d;
        end
    end

    assign douta = douta_q;
endmodule

// File: tb/tb_dual_port_ram.sv
// Directed + randomized checks of dual_port_ram against an array-based reference model.
module tb_dual_port_ram;
    localparam int DW = 8;
    localparam int AW = 13;
    localparam int DEPTH = 2 ** AW;

    logic          clock;
    logic          reset;
    logic [AW-1:0] addra;
    logic [DW-1:0] douta;
    logic          wea;
    logic          ena;
    logic [AW-1:0] addrb;
    logic [DW-1:0] dinb;
    logic          web;
    logic          enb;

    int checks;
    int failures;

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_dout;

    dual_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock (clock),
        .reset (reset),
        .addra (addra),
        .douta (douta),
        .wea   (wea),
        .ena   (ena),
        .addrb (addrb),
        .dinb  (dinb),
        .web   (web),
        .enb   (enb)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, apply the RAM's documented rules to the model, then
    // compare on the following falling edge.
    task automatic cycle(input string tag);
        @(posedge clock);
        if (reset) begin
            exp_dout = '0;
        end else begin
            if (ena) exp_dout = ref_mem[addra];
            if (web) ref_mem[addrb] = dinb;
        end
        @(negedge clock);
        check(tag, douta, exp_dout);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_dout = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        reset = 1'b1;
        addra = '0; addrb = '0; dinb = '0;
        wea = 1'b0; ena = 1'b0; web = 1'b0; enb = 1'b0;
        #3;
        check("reset_initial", douta, 8'h00);

        @(negedge clock);
        reset = 1'b0;

        // Write then read
        web = 1'b1; addrb = 13'd5; dinb = 8'h3C;
        cycle("wr5");
        web = 1'b0; ena = 1'b1; addra = 13'd5;
        cycle("rd5_model");
        check("rd5_latency", douta, 8'h3C);

        // Enable hold
        ena = 1'b0; addra = 13'd7;
        for (int i = 0; i < 3; i++) begin
            cycle("hold_model");
            check("hold", douta, 8'h3C);
        end

        // Collision: read-first
        web = 1'b1; addrb = 13'd7; dinb = 8'h11;
        cycle("pre_coll");
        web = 1'b1; addrb = 13'd7; dinb = 8'h22; ena = 1'b1; addra = 13'd7;
        cycle("coll_model");
        check("coll_old", douta, 8'h11);
        web = 1'b0;
        cycle("coll_next_model");
        check("coll_new", douta, 8'h22);

        // Reserved pins: enb=0 still writes, wea on port A does nothing
        ena = 1'b0; enb = 1'b0; wea = 1'b1; web = 1'b1; addrb = 13'd9; dinb = 8'h5A;
        cycle("resv_wr");
        web = 1'b0; ena = 1'b1; addra = 13'd9;
        cycle("resv_model");
        check("resv_rd", douta, 8'h5A);
        wea = 1'b0;

        // Boundaries
        ena = 1'b0; web = 1'b1; addrb = 13'd8191; dinb = 8'hFF;
        cycle("wr_top");
        addrb = 13'd0; dinb = 8'h01;
        cycle("wr_zero");
        web = 1'b0; ena = 1'b1; addra = 13'd8191;
        cycle("rd_top_model");
        check("rd_top", douta, 8'hFF);
        addra = 13'd0;
        cycle("rd_zero_model");
        check("rd_zero", douta, 8'h01);
        addra = 13'd100;
        cycle("rd_unwritten_model");
        check("rd_unwritten", douta, 8'h00);

        // Reset: async clear of a nonzero output, writes blocked while held
        ena = 1'b0; web = 1'b1; addrb = 13'd12; dinb = 8'hA5;
        cycle("wr12");
        web = 1'b0; ena = 1'b1; addra = 13'd12;
        cycle("rd12_model");
        check("rd12", douta, 8'hA5);
        reset = 1'b1;
        exp_dout = '0;
        #1;
        check("reset_async", douta, 8'h00);
        web = 1'b1; addrb = 13'd12; dinb = 8'h66;
        cycle("reset_hold0");
        cycle("reset_hold1");
        reset = 1'b0; web = 1'b0; addra = 13'd0;
        cycle("post_reset_rd0_model");
        check("post_reset_rd0", douta, 8'h01);
        addra = 13'd12;
        cycle("post_reset_rd12_model");
        check("write_blocked_in_reset", douta, 8'hA5);

        // Randomized traffic over a narrow window to provoke collisions
        for (int i = 0; i < 400; i++) begin
            ena   = 1'($urandom_range(0, 1));
            web   = 1'($urandom_range(0, 1));
            wea   = 1'($urandom_range(0, 1));
            enb   = 1'($urandom_range(0, 1));
            dinb  = 8'($urandom);
            addra = ($urandom_range(0, 1) == 1) ? 13'($urandom_range(0, 15))
                                                : 13'($urandom_range(8184, 8191));
            addrb = ($urandom_range(0, 3) == 0) ? addra
                  : (($urandom_range(0, 1) == 1) ? 13'($urandom_range(0, 15))
                                                 : 13'($urandom_range(8184, 8191)));
            cycle("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
